// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, HI/LO read
// select values and default latencies. The decoder imports this as well so
// that mdu_op/rd_sel encodings stay in one place.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam logic MDU_RD_LO = 1'b0;
    localparam logic MDU_RD_HI = 1'b1;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // True for every encoding that writes HI and/or LO (NONE and the
    // reserved code are both no-ops).
    function automatic logic mdu_is_write_op(input logic [2:0] op);
        return (op != MDU_NONE) && (op != MDU_RSVD);
    endfunction

    // True for the signed flavours of multiply and divide.
    function automatic logic mdu_is_signed(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    // True for the divide flavours (result is quotient/remainder).
    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_core_arith.sv
// Combinational arithmetic for the MDU: signed/unsigned multiply producing a
// 2*WIDTH product split into {hi, lo}, and signed/unsigned divide producing
// {remainder, quotient}. Divide is done on magnitudes so that truncation
// toward zero and "remainder has the dividend's sign" fall out directly.
module mdu_core_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    logic               is_signed;
    logic               is_div;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_safe;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Multiply: an unsigned 2W x 2W product of sign/zero-extended operands,
    // truncated to 2W bits, equals the exact signed/unsigned product.
    always_comb begin
        is_signed = mdu_is_signed(op);
        is_div    = mdu_is_div(op);
        ext_a     = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        ext_b     = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        product   = ext_a * ext_b;
    end

    // Divide on magnitudes, then restore signs. Most-negative / -1 yields a
    // magnitude of 2^(W-1) which, left positive, reads back as most-negative
    // with a zero remainder, so the overflow case needs no special path.
    always_comb begin
        div_zero = (b == '0);
        a_neg    = is_signed && a[WIDTH-1];
        b_neg    = is_signed && b[WIDTH-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
        // A zero divisor is replaced so no X/undefined divide is inferred;
        // the result is discarded by the caller in that case anyway.
        b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        rem      = a_neg ? (~r_mag + 1'b1) : r_mag;
    end

    // Select which result pair feeds the pending registers.
    always_comb begin
        hi = product[2*WIDTH-1:WIDTH];
        lo = product[WIDTH-1:0];
        if (is_div) begin
            hi = rem;
            lo = quot;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// A mult/div result is computed at acceptance, parked in pend_hi/pend_lo and
// committed to HI/LO only when the latency counter runs out, so the pipeline
// sees the same timing as a true iterative unit. busy decodes the counter.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdu_op,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic             rd_sel,
    output logic             busy,
    output logic [WIDTH-1:0] mdu_res,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic [WIDTH-1:0] pend_hi_reg, pend_hi_next;
    logic [WIDTH-1:0] pend_lo_reg, pend_lo_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             no_commit_reg, no_commit_next;

    logic             accept;
    logic [WIDTH-1:0] arith_hi;
    logic [WIDTH-1:0] arith_lo;
    logic             arith_div_zero;

    mdu_core_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op       (mdu_op),
        .a        (A1),
        .b        (A2),
        .hi       (arith_hi),
        .lo       (arith_lo),
        .div_zero (arith_div_zero)
    );

    // Next-state logic: count down and commit while busy, otherwise accept
    // a new command. Commands arriving while busy are dropped, not queued.
    always_comb begin
        hi_next        = hi_reg;
        lo_next        = lo_reg;
        pend_hi_next   = pend_hi_reg;
        pend_lo_next   = pend_lo_reg;
        count_next     = count_reg;
        no_commit_next = no_commit_reg;
        accept         = start && (count_reg == '0) && mdu_is_write_op(mdu_op);

        if (count_reg != '0) begin
            count_next = count_reg - CW'(1);
            if ((count_reg == CW'(1)) && !no_commit_reg) begin
                hi_next = pend_hi_reg;
                lo_next = pend_lo_reg;
            end
        end else if (accept) begin
            case (mdu_op_e'(mdu_op))
                MDU_MULT, MDU_MULTU: begin
                    pend_hi_next   = arith_hi;
                    pend_lo_next   = arith_lo;
                    count_next     = CW'(MULT_CYCLES);
                    no_commit_next = 1'b0;
                end
                MDU_DIV, MDU_DIVU: begin
                    pend_hi_next   = arith_hi;
                    pend_lo_next   = arith_lo;
                    count_next     = CW'(DIV_CYCLES);
                    // Divide by zero still occupies the unit but never commits.
                    no_commit_next = arith_div_zero;
                end
                MDU_MTHI: hi_next = A1;
                MDU_MTLO: lo_next = A1;
                default: ;
            endcase
        end
    end

    // State registers; reset discards any in-flight operation immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg        <= '0;
            lo_reg        <= '0;
            pend_hi_reg   <= '0;
            pend_lo_reg   <= '0;
            count_reg     <= '0;
            no_commit_reg <= 1'b0;
        end else begin
            hi_reg        <= hi_next;
            lo_reg        <= lo_next;
            pend_hi_reg   <= pend_hi_next;
            pend_lo_reg   <= pend_lo_next;
            count_reg     <= count_next;
            no_commit_reg <= no_commit_next;
        end
    end

    // Read side: plain decode of the architectural registers, no forwarding.
    always_comb begin
        busy    = (count_reg != '0);
        hi_q    = hi_reg;
        lo_q    = lo_reg;
        mdu_res = (rd_sel == MDU_RD_HI) ? hi_reg : lo_reg;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed scenarios followed by random
// operations, all compared against an arithmetic model of HI/LO.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int W     = 32;
    localparam int MULTC = 5;
    localparam int DIVC  = 10;

    logic          clk;
    logic          reset;
    logic          start;
    logic [2:0]    mdu_op;
    logic [W-1:0]  A1;
    logic [W-1:0]  A2;
    logic          rd_sel;
    logic          busy;
    logic [W-1:0]  mdu_res;
    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    mdu_unit #(
        .WIDTH       (W),
        .MULT_CYCLES (MULTC),
        .DIV_CYCLES  (DIVC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .A1      (A1),
        .A2      (A2),
        .rd_sel  (rd_sel),
        .busy    (busy),
        .mdu_res (mdu_res),
        .hi_q    (hi_q),
        .lo_q    (lo_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return MULTC;
            3'd3, 3'd4: return DIVC;
            default:    return 0;
        endcase
    endfunction

    // Architectural effect of one accepted op, written from the ISA rules.
    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd1: begin
                sp   = longint'(sa) * longint'(sb);
                hi_m = sp[63:32];
                lo_m = sp[31:0];
            end
            3'd2: begin
                up   = longint'({32'b0, a}) * longint'({32'b0, b});
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            3'd3: begin
                if (sb != 0) begin
                    if (sa == 32'sh8000_0000 && sb == -1) begin
                        lo_m = 32'h8000_0000;
                        hi_m = 32'h0;
                    end else begin
                        lo_m = sa / sb;
                        hi_m = sa % sb;
                    end
                end
            end
            3'd4: begin
                if (b != 0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one op (caller is at a falling edge), check busy and the old
    // values for every busy cycle, then the committed values.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] oh, ol;
        int n;
        oh = hi_m;
        ol = lo_m;
        n  = lat(op);
        model_apply(op, a, b);
        start  = 1'b1;
        mdu_op = op;
        A1     = a;
        A2     = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'd0;
        A1     = $urandom;
        A2     = $urandom;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_busy"}, 64'(busy), 64'(1));
            rd_sel = 1'($urandom_range(0, 1));
            #1 chk({tag, "_res_old"}, 64'(mdu_res), 64'(rd_sel ? oh : ol));
        end
        if (n > 0) @(negedge clk);
        chk({tag, "_idle"}, 64'(busy), 64'(0));
        chk({tag, "_hi"}, 64'(hi_q), 64'(hi_m));
        chk({tag, "_lo"}, 64'(lo_q), 64'(lo_m));
        rd_sel = MDU_RD_HI;
        #1 chk({tag, "_res_hi"}, 64'(mdu_res), 64'(hi_m));
        rd_sel = MDU_RD_LO;
        #1 chk({tag, "_res_lo"}, 64'(mdu_res), 64'(lo_m));
        $display("op %0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hi_q, lo_q);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'd0;
        A1     = '0;
        A2     = '0;
        rd_sel = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(hi_q), 64'(0));
        chk("rst_lo", 64'(lo_q), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        // Directed arithmetic cases
        do_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult_neg_hi_c", 64'(hi_q), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg_lo_c", 64'(lo_q), 64'h0000_0000_FFFF_FFF1);
        do_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_hi_c", 64'(hi_q), 64'd1);
        do_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_c", 64'(lo_q), 64'h0000_0000_FFFF_FFFD);
        do_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_c", 64'(lo_q), 64'h0000_0000_8000_0000);
        do_op("mthi", MDU_MTHI, 32'h11, 32'h0);
        do_op("mtlo", MDU_MTLO, 32'h22, 32'h0);
        do_op("divu_zero", MDU_DIVU, 32'h1234, 32'h0);
        chk("divu_zero_hi_c", 64'(hi_q), 64'h11);
        do_op("div_zero", MDU_DIV, 32'h1234, 32'h0);
        do_op("mtlo2", MDU_MTLO, 32'h1234, 32'h0);
        do_op("nop", MDU_NONE, 32'h5555, 32'h1);
        do_op("rsvd", MDU_RSVD, 32'h6666, 32'h1);

        // Commands issued while busy must be ignored
        model_apply(MDU_MULT, 32'd7, 32'd9);
        start  = 1'b1;
        mdu_op = MDU_MULT;
        A1     = 32'd7;
        A2     = 32'd9;
        @(negedge clk);
        mdu_op = MDU_MTHI;
        A1     = 32'hABCD;
        @(negedge clk);
        mdu_op = MDU_DIV;
        A1     = 32'd100;
        A2     = 32'd3;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = MDU_NONE;
        chk("ign_busy", 64'(busy), 64'(1));
        repeat (3) @(negedge clk);
        chk("ign_idle", 64'(busy), 64'(0));
        chk("ign_hi", 64'(hi_q), 64'(hi_m));
        chk("ign_lo", 64'(lo_q), 64'(lo_m));
        repeat (2) @(negedge clk);
        chk("ign_noqueue", 64'(busy), 64'(0));
        $display("ignore-while-busy: hi=%h lo=%h", hi_q, lo_q);

        // Asynchronous reset mid-divide: immediate clear, no late commit
        start  = 1'b1;
        mdu_op = MDU_DIV;
        A1     = 32'd100;
        A2     = 32'd7;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = MDU_NONE;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_hi", 64'(hi_q), 64'(0));
        chk("arst_lo", 64'(lo_q), 64'(0));
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("arst_nocommit_busy", 64'(busy), 64'(0));
        chk("arst_nocommit_hi", 64'(hi_q), 64'(0));
        chk("arst_nocommit_lo", 64'(lo_q), 64'(0));
        $display("reset mid-divide: hi=%h lo=%h", hi_q, lo_q);

        // First edge after reset release accepts a new op
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        do_op("post_rst_mult", MDU_MULT, 32'd1000, 32'hFFFF_FFFE);

        // Random ops against the model
        for (int k = 0; k < 24; k++) begin
            rop = 3'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            do_op("rnd", rop, ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
